// File: rtl/parking_pkg.sv
// Shared constants and FSM state type for the parking slot allocator.
package parking_pkg;

  localparam int NUM_SLOTS   = 8;
  localparam int SLOT_W      = 3;
  localparam int GATE_CYCLES = 16;

  // Entry-gate sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    OPEN  = 2'd2,
    CLOSE = 2'd3
  } gate_state_t;

endpackage

// File: rtl/parking_slot_allocator_encoder.sv
// Lowest-index priority encoder over the free-slot vector.
module slot_priority_encoder #(
  parameter int NUM_SLOTS = 8,
  parameter int SLOT_W    = 3
) (
  input  logic [NUM_SLOTS-1:0] free_vec,
  output logic [SLOT_W-1:0]    lowest_idx,
  output logic                 any_free
);

  // Scan from the top down so the lowest free index wins last.
  always_comb begin
    lowest_idx = '0;
    any_free   = |free_vec;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (free_vec[i]) begin
        lowest_idx = SLOT_W'(i);
      end
    end
  end

endmodule

// File: rtl/parking_slot_allocator.sv
// Parking slot allocator: owns the occupancy vector, grants the lowest free
// slot to entering cars, sequences the entry gate and frees slots on exit.
//
// Handshake note: car_enter, car_exit and car_passed are single-cycle
// qualifiers with no backpressure. A request that cannot be served in the
// cycle it is presented is refused with a one-cycle pulse (entry_reject or
// exit_err); nothing is ever queued.
module parking_slot_allocator
  import parking_pkg::*;
#(
  parameter int NUM_SLOTS_P   = NUM_SLOTS,
  parameter int SLOT_W_P      = SLOT_W,
  parameter int GATE_CYCLES_P = GATE_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   car_enter,
  input  logic                   car_passed,
  input  logic                   car_exit,
  input  logic [SLOT_W_P-1:0]    exit_slot,
  output logic [NUM_SLOTS_P-1:0] new_capacity,
  output logic [SLOT_W_P-1:0]    assigned_slot,
  output logic                   slot_valid,
  output logic                   gate_open,
  output logic                   entry_reject,
  output logic                   exit_err,
  output logic                   full
);

  localparam int TIMER_W = (GATE_CYCLES_P > 2) ? $clog2(GATE_CYCLES_P) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(GATE_CYCLES_P - 1);

  gate_state_t            state_q, state_d;
  logic [TIMER_W-1:0]     timer_q, timer_d;
  logic [SLOT_W_P-1:0]    grant_slot_q, grant_slot_d;
  logic [NUM_SLOTS_P-1:0] occupancy_q, occupancy_d;
  logic [SLOT_W_P-1:0]    assigned_slot_q, assigned_slot_d;
  logic                   slot_valid_q, slot_valid_d;
  logic                   gate_open_q, gate_open_d;
  logic                   entry_reject_q, entry_reject_d;
  logic                   exit_err_q, exit_err_d;
  logic                   full_q, full_d;

  logic                   exit_hit;
  logic [NUM_SLOTS_P-1:0] exit_mask;
  logic [NUM_SLOTS_P-1:0] occ_after_exit;
  logic [SLOT_W_P-1:0]    lowest_free;
  logic                   any_free;

  // Exit is applied before allocation so a car leaving a full lot makes room
  // for a car entering in the same cycle.
  always_comb begin
    exit_hit       = car_exit & occupancy_q[exit_slot];
    exit_mask      = exit_hit ? (NUM_SLOTS_P'(1) << exit_slot) : '0;
    occ_after_exit = occupancy_q & ~exit_mask;
  end

  slot_priority_encoder #(
    .NUM_SLOTS (NUM_SLOTS_P),
    .SLOT_W    (SLOT_W_P)
  ) u_encoder (
    .free_vec   (~occ_after_exit),
    .lowest_idx (lowest_free),
    .any_free   (any_free)
  );

  // Next-state logic for the gate sequencer, occupancy and all registered outputs.
  always_comb begin
    state_d         = state_q;
    timer_d         = timer_q;
    grant_slot_d    = grant_slot_q;
    occupancy_d     = occ_after_exit;
    assigned_slot_d = assigned_slot_q;
    slot_valid_d    = 1'b0;
    gate_open_d     = gate_open_q;
    entry_reject_d  = 1'b0;
    exit_err_d      = car_exit & ~occupancy_q[exit_slot];

    case (state_q)
      IDLE: begin
        if (car_enter) begin
          if (any_free) begin
            grant_slot_d = lowest_free;
            state_d      = GRANT;
          end else begin
            entry_reject_d = 1'b1;
          end
        end
      end
      GRANT: begin
        occupancy_d     = occ_after_exit | (NUM_SLOTS_P'(1) << grant_slot_q);
        assigned_slot_d = grant_slot_q;
        slot_valid_d    = 1'b1;
        gate_open_d     = 1'b1;
        timer_d         = TIMER_LOAD;
        entry_reject_d  = car_enter;
        state_d         = OPEN;
      end
      OPEN: begin
        entry_reject_d = car_enter;
        if (car_passed || (timer_q == '0)) begin
          state_d = CLOSE;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      CLOSE: begin
        entry_reject_d = car_enter;
        gate_open_d    = 1'b0;
        state_d        = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    full_d = &occupancy_d;
  end

  // State and output registers; reset clears everything including the gate drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      timer_q         <= '0;
      grant_slot_q    <= '0;
      occupancy_q     <= '0;
      assigned_slot_q <= '0;
      slot_valid_q    <= 1'b0;
      gate_open_q     <= 1'b0;
      entry_reject_q  <= 1'b0;
      exit_err_q      <= 1'b0;
      full_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      grant_slot_q    <= grant_slot_d;
      occupancy_q     <= occupancy_d;
      assigned_slot_q <= assigned_slot_d;
      slot_valid_q    <= slot_valid_d;
      gate_open_q     <= gate_open_d;
      entry_reject_q  <= entry_reject_d;
      exit_err_q      <= exit_err_d;
      full_q          <= full_d;
    end
  end

  assign new_capacity  = occupancy_q;
  assign assigned_slot = assigned_slot_q;
  assign slot_valid    = slot_valid_q;
  assign gate_open     = gate_open_q;
  assign entry_reject  = entry_reject_q;
  assign exit_err      = exit_err_q;
  assign full          = full_q;

endmodule

// File: tb/tb_parking_slot_allocator.sv
// Testbench for parking_slot_allocator: directed scenarios followed by random
// traffic, all checked against an edge-timed behavioural model of the lot.
module tb_parking_slot_allocator;
  import parking_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              car_enter = 1'b0;
  logic              car_passed = 1'b0;
  logic              car_exit = 1'b0;
  logic [SLOT_W-1:0] exit_slot = '0;
  logic [NUM_SLOTS-1:0] new_capacity;
  logic [SLOT_W-1:0]    assigned_slot;
  logic slot_valid, gate_open, entry_reject, exit_err, full;

  parking_slot_allocator dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .car_enter     (car_enter),
    .car_passed    (car_passed),
    .car_exit      (car_exit),
    .exit_slot     (exit_slot),
    .new_capacity  (new_capacity),
    .assigned_slot (assigned_slot),
    .slot_valid    (slot_valid),
    .gate_open     (gate_open),
    .entry_reject  (entry_reject),
    .exit_err      (exit_err),
    .full          (full)
  );

  // ---------------- reference model ----------------
  // The lot is an array of taken flags. An admitted car is described by the
  // edge at which its grant lands and the edge at which the gate starts to
  // close; the entry path is busy from admission until one edge after that.
  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;
  int          edge_n = 0;
  bit          occ_m[NUM_SLOTS];
  int          grant_edge = -1;
  int          close_edge = -1;
  int          grant_slot = 0;
  logic [SLOT_W-1:0] exp_assigned = '0;
  logic exp_valid = 0, exp_gate = 0, exp_reject = 0, exp_err = 0;

  task automatic model_reset();
    for (int i = 0; i < NUM_SLOTS; i++) occ_m[i] = 1'b0;
    grant_edge   = -1;
    close_edge   = -1;
    exp_assigned = '0;
    exp_valid    = 0;
    exp_gate     = 0;
    exp_reject   = 0;
    exp_err      = 0;
  endtask

  function automatic logic [NUM_SLOTS-1:0] model_vec();
    logic [NUM_SLOTS-1:0] v;
    for (int i = 0; i < NUM_SLOTS; i++) v[i] = occ_m[i];
    return v;
  endfunction

  function automatic logic model_full();
    for (int i = 0; i < NUM_SLOTS; i++) if (!occ_m[i]) return 1'b0;
    return 1'b1;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s @edge %0d: observed %0h expected %0h", tag, edge_n, observed, expected);
    end
  endtask

  task automatic check_all();
    check("new_capacity",  32'(new_capacity),  32'(model_vec()));
    check("full",          32'(full),          32'(model_full()));
    check("assigned_slot", 32'(assigned_slot), 32'(exp_assigned));
    check("slot_valid",    32'(slot_valid),    32'(exp_valid));
    check("gate_open",     32'(gate_open),     32'(exp_gate));
    check("entry_reject",  32'(entry_reject),  32'(exp_reject));
    check("exit_err",      32'(exit_err),      32'(exp_err));
  endtask

  // ---------------- driver ----------------
  // Drive one cycle of inputs, predict the outcome of the coming edge, then
  // sample the DUT 1 time unit after that edge.
  task automatic step(input logic en, input logic ps, input logic ex, input logic [SLOT_W-1:0] sl);
    bit busy;
    int lo;
    car_enter  = en;
    car_passed = ps;
    car_exit   = ex;
    exit_slot  = sl;

    exp_valid  = 0;
    exp_reject = 0;
    exp_err    = 0;
    busy = (grant_edge >= 0);

    if (ex) begin
      if (occ_m[sl]) occ_m[sl] = 1'b0;
      else exp_err = 1;
    end

    if (busy) begin
      if (edge_n == grant_edge) begin
        occ_m[grant_slot] = 1'b1;
        exp_assigned = SLOT_W'(grant_slot);
        exp_valid = 1;
        exp_gate  = 1;
      end else if (close_edge < 0) begin
        if (ps || edge_n == grant_edge + GATE_CYCLES) close_edge = edge_n;
      end else if (edge_n == close_edge + 1) begin
        exp_gate = 0;
      end
    end

    if (en) begin
      if (busy) begin
        exp_reject = 1;
      end else begin
        lo = -1;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) if (!occ_m[i]) lo = i;
        if (lo < 0) exp_reject = 1;
        else begin
          grant_edge = edge_n + 1;
          grant_slot = lo;
        end
      end
    end

    if (busy && close_edge >= 0 && edge_n == close_edge + 1) begin
      grant_edge = -1;
      close_edge = -1;
    end

    @(posedge clk);
    #1;
    edge_n++;
    check_all();
  endtask

  // One full admission closed promptly by car_passed.
  task automatic admit();
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  int gate_cnt;
  logic saw_reject;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_capacity", 32'(new_capacity), 32'h0);
    check("reset_gate",     32'(gate_open),    32'h0);
    rst_n = 1'b1;

    // 1: first car into an empty lot
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    check("t1_slot",  32'(assigned_slot), 32'd0);
    check("t1_cap",   32'(new_capacity),  32'h01);
    check("t1_gate",  32'(gate_open),     32'd1);
    check("t1_valid", 32'(slot_valid),    32'd1);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);

    // 2: fill the lot, then one car too many
    for (int k = 0; k < NUM_SLOTS - 1; k++) admit();
    check("t2_cap",  32'(new_capacity), 32'hFF);
    check("t2_full", 32'(full),         32'd1);
    step(1, 0, 0, 0);
    check("t2_reject",   32'(entry_reject), 32'd1);
    check("t2_cap_held", 32'(new_capacity), 32'hFF);

    // 3: exit and entry together on a full lot
    step(1, 0, 1, 3'd5);
    check("t3_no_reject", 32'(entry_reject), 32'd0);
    step(0, 0, 0, 0);
    check("t3_slot", 32'(assigned_slot), 32'd5);
    check("t3_cap",  32'(new_capacity),  32'hFF);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);

    // 4: empty down to slot 0, exit of a free slot, then last exit
    for (int s = 1; s < NUM_SLOTS; s++) step(0, 0, 1, SLOT_W'(s));
    check("t4_cap01", 32'(new_capacity), 32'h01);
    step(0, 0, 1, 3'd3);
    check("t4_exit_err", 32'(exit_err),     32'd1);
    check("t4_cap_held", 32'(new_capacity), 32'h01);
    step(0, 0, 1, 3'd0);
    check("t4_empty", 32'(new_capacity), 32'h00);

    // 5: gate times out with no car_passed; entry attempt while open
    step(1, 0, 0, 0);
    gate_cnt = 0;
    saw_reject = 0;
    for (int k = 0; k < 25; k++) begin
      step((k == 5), 0, 0, 0);
      if (k == 5) saw_reject = entry_reject;
      if (gate_open) gate_cnt++;
    end
    check("t5_gate_cycles", 32'(gate_cnt),   32'(GATE_CYCLES + 1));
    check("t5_open_reject", 32'(saw_reject), 32'd1);
    check("t5_no_rollback", 32'(new_capacity), 32'h01);

    // 6: reset while the gate is open with four slots taken
    admit();
    admit();
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    check("t6_pre_cap",  32'(new_capacity), 32'h0F);
    check("t6_pre_gate", 32'(gate_open),    32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_gate", 32'(gate_open),    32'd0);
    check("t6_cap",  32'(new_capacity), 32'h00);
    check("t6_full", 32'(full),         32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    check("t6_restart_slot", 32'(assigned_slot), 32'd0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(0, 99) < 35), ($urandom_range(0, 99) < 15),
           ($urandom_range(0, 99) < 25), SLOT_W'($urandom_range(0, NUM_SLOTS - 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
